int_dot_accum: RTL and testbench

//   Signed integer dot-product accumulator directly upstream of int_to_fp16.

---
 rtl/fp16_pkg.sv | 32 +++
 rtl/int_dot_accum_if.sv | 31 +++
 rtl/int_dot_mac.sv | 57 +++++
 rtl/int_dot_accum.sv | 93 +++++++++
 tb/tb_int_dot_accum.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp16_pkg.sv
// fp16_pkg: definitions shared between int_dot_accum and int_to_fp16.
//   FP16_ACC_W  : integer width handed to the FP16 converter (20)
//   dot_state_t : int_dot_accum FSM states
//   sat_add     : ACC_W-bit signed add returning {sum, ovf}. On overflow the
//                 sum is clamped to the nearest representable extreme.
package fp16_pkg;

  localparam int FP16_ACC_W = 20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } dot_state_t;

  function automatic logic [FP16_ACC_W:0] sat_add(
    input logic signed [FP16_ACC_W-1:0] acc,
    input logic signed [FP16_ACC_W-1:0] prod
  );
    logic [FP16_ACC_W:0]   wide;
    logic [FP16_ACC_W-1:0] sum;
    logic                  ovf;
    // One guard bit: overflow shows up as guard != MSB of the result.
    wide = {acc[FP16_ACC_W-1], acc} + {prod[FP16_ACC_W-1], prod};
    ovf  = wide[FP16_ACC_W] ^ wide[FP16_ACC_W-1];
    if (!ovf)                 sum = wide[FP16_ACC_W-1:0];
    else if (wide[FP16_ACC_W]) sum = {1'b1, {(FP16_ACC_W-1){1'b0}}};
    else                      sum = {1'b0, {(FP16_ACC_W-1){1'b1}}};
    return {sum, ovf};
  endfunction

endpackage

// File: rtl/int_dot_accum_if.sv
// int_dot_accum_if: operand stream in, finished sum out to the FP16 converter.
//   in_valid/in_ready/in_a/in_b/in_last : operand beat handshake
//   conv_valid/conv_int/conv_done       : held result level + converter done pulse
//   forced_end                          : sum closed by MAX_TERMS
//   sat_flag                            : saturation seen in the current sum
// Modports: slave = the accumulator, master = upstream source plus converter.
interface int_dot_accum_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = fp16_pkg::FP16_ACC_W
) ();
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_a;
  logic signed [DATA_W-1:0] in_b;
  logic                     in_last;
  logic                     conv_valid;
  logic signed [ACC_W-1:0]  conv_int;
  logic                     conv_done;
  logic                     forced_end;
  logic                     sat_flag;

  modport slave (
    input  in_valid, in_a, in_b, in_last, conv_done,
    output in_ready, conv_valid, conv_int, forced_end, sat_flag
  );

  modport master (
    output in_valid, in_a, in_b, in_last, conv_done,
    input  in_ready, conv_valid, conv_int, forced_end, sat_flag
  );
endinterface

// File: rtl/int_dot_mac.sv
// int_dot_mac: signed multiply-accumulate register for int_dot_accum.
// Macro: INT_DOT_ACCUM_SAT_EN selects clamping on overflow (plus a sticky
// flag); without it the accumulator wraps at ACC_W bits and o_sat is 0.
// The saturating path uses fp16_pkg::sat_add, so ACC_W must equal FP16_ACC_W
// when the macro is defined.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   i_en        : accept this beat (acc <= o_sum_next)
//   i_clr       : clear acc and sat flag (sum handed off)
//   i_a, i_b    : signed operands
//   o_sum_next  : acc + a*b, combinational; the value the acc takes on i_en
//   o_sat       : sticky saturation flag
module int_dot_mac
  import fp16_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = FP16_ACC_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_en,
  input  logic                     i_clr,
  input  logic signed [DATA_W-1:0] i_a,
  input  logic signed [DATA_W-1:0] i_b,
  output logic signed [ACC_W-1:0]  o_sum_next,
  output logic                     o_sat
);
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_prod_ext;
  logic signed [ACC_W-1:0]    r_acc;

  assign w_prod     = i_a * i_b;
  assign w_prod_ext = {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};

`ifdef INT_DOT_ACCUM_SAT_EN
  logic w_ovf;
  logic r_sat;

  assign {o_sum_next, w_ovf} = sat_add(r_acc, w_prod_ext);
  assign o_sat = r_sat;

  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) r_sat <= 1'b0;
    else if (i_en && w_ovf) r_sat <= 1'b1;
  end
`else
  assign o_sum_next = r_acc + w_prod_ext;
  assign o_sat      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n)     r_acc <= '0;
    else if (i_clr) r_acc <= '0;
    else if (i_en)  r_acc <= o_sum_next;
  end

endmodule

// File: rtl/int_dot_accum.sv
// int_dot_accum: signed integer dot-product accumulator feeding int_to_fp16.
// MACs operand pairs into an ACC_W-bit sum; the sum closes on in_last or on
// the MAX_TERMS-th beat, then is held on conv_valid/conv_int until the
// converter pulses conv_done.
// Macro: INT_DOT_ACCUM_SAT_EN (saturating accumulate, see int_dot_mac).
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : int_dot_accum_if.slave (operand stream + converter handshake)
module int_dot_accum
  import fp16_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ACC_W     = FP16_ACC_W,
  parameter int MAX_TERMS = 16
) (
  input logic            clk,
  input logic            rst_n,
  int_dot_accum_if.slave bus
);
  localparam int CNT_W = (MAX_TERMS > 1) ? $clog2(MAX_TERMS) : 1;

  dot_state_t              r_state;
  logic [CNT_W-1:0]        r_term_cnt;
  logic signed [ACC_W-1:0] r_conv_int;
  logic                    r_forced_end;
  logic signed [ACC_W-1:0] w_sum;
  logic                    w_sat;
  logic                    w_ready;
  logic                    w_accept;
  logic                    w_close;
  logic                    w_release;

  assign w_ready   = (r_state != HOLD);
  assign w_accept  = bus.in_valid & w_ready;
  assign w_close   = bus.in_last | (r_term_cnt == CNT_W'(MAX_TERMS-1));
  assign w_release = (r_state == HOLD) & bus.conv_done;

  int_dot_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (w_accept),
    .i_clr      (w_release),
    .i_a        (bus.in_a),
    .i_b        (bus.in_b),
    .o_sum_next (w_sum),
    .o_sat      (w_sat)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_term_cnt   <= '0;
      r_conv_int   <= '0;
      r_forced_end <= 1'b0;
    end else begin
      r_forced_end <= 1'b0;
      unique case (r_state)
        IDLE, ACCUM: begin
          if (w_accept) begin
            r_term_cnt <= r_term_cnt + CNT_W'(1);
            if (w_close) begin
              // Capture the sum including the closing beat so the converter
              // sees it on the very next cycle.
              r_state      <= HOLD;
              r_conv_int   <= w_sum;
              r_forced_end <= ~bus.in_last;
            end else begin
              r_state <= ACCUM;
            end
          end
        end
        HOLD: begin
          // conv_int deliberately keeps its value after release.
          if (bus.conv_done) begin
            r_state    <= IDLE;
            r_term_cnt <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = w_ready;
  assign bus.conv_valid = (r_state == HOLD);
  assign bus.conv_int   = r_conv_int;
  assign bus.forced_end = r_forced_end;
  assign bus.sat_flag   = w_sat;

endmodule

// File: tb/tb_int_dot_accum.sv
// tb_int_dot_accum: self-checking bench for int_dot_accum.
// dut0 uses the default MAX_TERMS=16, dut1 uses MAX_TERMS=64 for the
// overflow case; `sel` routes the shared stimulus to one of them.
module tb_int_dot_accum;
  import fp16_pkg::*;

  localparam int DW  = 8;
  localparam int AW  = FP16_ACC_W;
  localparam int MT0 = 16;
  localparam int MT1 = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int_dot_accum_if #(.DATA_W(DW), .ACC_W(AW)) bus0 ();
  int_dot_accum_if #(.DATA_W(DW), .ACC_W(AW)) bus1 ();

  int_dot_accum #(.DATA_W(DW), .ACC_W(AW), .MAX_TERMS(MT0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  int_dot_accum #(.DATA_W(DW), .ACC_W(AW), .MAX_TERMS(MT1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  logic sel = 1'b0, v_valid = 1'b0, v_last = 1'b0, v_done = 1'b0;
  logic signed [DW-1:0] v_a = '0, v_b = '0;

  assign bus0.in_valid  = v_valid & ~sel;
  assign bus1.in_valid  = v_valid & sel;
  assign bus0.in_a      = v_a;
  assign bus1.in_a      = v_a;
  assign bus0.in_b      = v_b;
  assign bus1.in_b      = v_b;
  assign bus0.in_last   = v_last;
  assign bus1.in_last   = v_last;
  assign bus0.conv_done = v_done;
  assign bus1.conv_done = v_done;

  logic o_ready, o_valid, o_forced, o_sat;
  logic signed [AW-1:0] o_int;
  assign o_ready  = sel ? bus1.in_ready   : bus0.in_ready;
  assign o_valid  = sel ? bus1.conv_valid : bus0.conv_valid;
  assign o_int    = sel ? bus1.conv_int   : bus0.conv_int;
  assign o_forced = sel ? bus1.forced_end : bus0.forced_end;
  assign o_sat    = sel ? bus1.sat_flag   : bus0.sat_flag;

  int total = 0;
  int bad   = 0;
  int qa[$];
  int qb[$];

  // Reference: plain integer sum of the beats up to the closing one, then
  // either clamped after every add or reduced modulo 2^AW.
  function automatic void model(input int max_terms, output logic [AW-1:0] e_int,
                                output bit e_sat);
    longint s = 0;
    longint lim = longint'(1) <<< (AW-1);
    e_sat = 1'b0;
    for (int i = 0; i < qa.size() && i < max_terms; i++) begin
      s += longint'(qa[i]) * longint'(qb[i]);
`ifdef INT_DOT_ACCUM_SAT_EN
      if (s > lim - 1) begin s = lim - 1; e_sat = 1'b1; end
      else if (s < -lim) begin s = -lim; e_sat = 1'b1; end
`else
      s = s & (2*lim - 1);
      if (s >= lim) s -= 2*lim;
`endif
    end
    e_int = s[AW-1:0];
  endfunction

  // Drives beats from qa/qb up to the closing one; returns at the falling
  // edge just after the closing accept.
  task automatic drive_sum(input int max_terms, input bit use_last, input bit bubbles);
    int n;
    n = (qa.size() < max_terms) ? qa.size() : max_terms;
    for (int i = 0; i < n; i++) begin
      while (bubbles && $urandom_range(0, 3) == 0) begin
        v_valid = 1'b0;
        v_done  = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      v_valid = 1'b1;
      v_a     = 8'(qa[i]);
      v_b     = 8'(qb[i]);
      v_last  = use_last && (i == qa.size() - 1);
      v_done  = bubbles ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
    end
    v_valid = 1'b0;
    v_last  = 1'b0;
    v_done  = 1'b0;
  endtask

  task automatic pulse_done();
    v_done = 1'b1;
    @(negedge clk);
    v_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      total++;
      if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_int !== '0 || o_forced !== 1'b0 ||
          o_sat !== 1'b0) begin
        bad++;
        $display("FAIL reset_dut%0d: ready=%0b valid=%0b int=%0d forced=%0b sat=%0b, expected 1/0/0/0/0",
                 s, o_ready, o_valid, o_int, o_forced, o_sat);
      end
    end
    sel   = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    sel = 1'b0;
    qa = '{1, 2, 3};
    qb = '{4, 5, 6};
    drive_sum(MT0, 1'b1, 1'b0);
    total++;
    if (o_valid !== 1'b1 || o_int !== 20'sd32 || o_forced !== 1'b0) begin
      bad++;
      $display("FAIL basic_close: valid=%0b int=%0d forced=%0b, expected 1/32/0",
               o_valid, o_int, o_forced);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_int !== 20'sd32) begin
        bad++;
        $display("FAIL basic_hold[%0d]: valid=%0b ready=%0b int=%0d, expected 1/0/32",
                 c, o_valid, o_ready, o_int);
      end
    end
    pulse_done();
    total++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_int !== 20'sd32) begin
      bad++;
      $display("FAIL basic_release: valid=%0b ready=%0b int=%0d, expected 0/1/32",
               o_valid, o_ready, o_int);
    end
  endtask

  task automatic test_single();
    sel = 1'b0;
    qa = '{-1};
    qb = '{1};
    drive_sum(MT0, 1'b1, 1'b0);
    total++;
    if (o_valid !== 1'b1 || o_int !== 20'hFFFFF || o_forced !== 1'b0) begin
      bad++;
      $display("FAIL single_beat: valid=%0b int=%0d forced=%0b, expected 1/-1/0",
               o_valid, o_int, o_forced);
    end
    pulse_done();
  endtask

  task automatic test_forced();
    sel = 1'b0;
    qa.delete();
    qb.delete();
    for (int i = 0; i < 16; i++) begin qa.push_back(-128); qb.push_back(-128); end
    drive_sum(MT0, 1'b0, 1'b0);
    total++;
    if (o_valid !== 1'b1 || o_int !== 20'sd262144 || o_forced !== 1'b1) begin
      bad++;
      $display("FAIL forced_close: valid=%0b int=%0d forced=%0b, expected 1/262144/1",
               o_valid, o_int, o_forced);
    end
    @(negedge clk);
    total++;
    if (o_forced !== 1'b0 || o_valid !== 1'b1) begin
      bad++;
      $display("FAIL forced_pulse: forced=%0b valid=%0b, expected 0/1", o_forced, o_valid);
    end
    pulse_done();
  endtask

  // Upstream keeps a beat valid through HOLD; it must wait for release and
  // then start a fresh sum from zero.
  task automatic test_hold_block();
    sel = 1'b0;
    qa = '{3};
    qb = '{5};
    drive_sum(MT0, 1'b1, 1'b0);
    v_valid = 1'b1;
    v_a     = 8'sd7;
    v_b     = -8'sd3;
    v_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      total++;
      if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_int !== 20'sd15) begin
        bad++;
        $display("FAIL hold_block[%0d]: ready=%0b valid=%0b int=%0d, expected 0/1/15",
                 c, o_ready, o_valid, o_int);
      end
      if (c == 4) v_done = 1'b1;
      @(negedge clk);
    end
    v_done = 1'b0;
    total++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_int !== 20'sd15) begin
      bad++;
      $display("FAIL hold_release: valid=%0b ready=%0b int=%0d, expected 0/1/15",
               o_valid, o_ready, o_int);
    end
    @(negedge clk);
    v_valid = 1'b0;
    v_last  = 1'b0;
    total++;
    if (o_valid !== 1'b1 || o_int !== -20'sd21) begin
      bad++;
      $display("FAIL hold_next_sum: valid=%0b int=%0d, expected 1/-21", o_valid, o_int);
    end
    pulse_done();
  endtask

  task automatic test_random();
    logic [AW-1:0] e;
    bit es, ul, ef;
    int len;
    sel = 1'b0;
    for (int it = 0; it < 24; it++) begin
      len = $urandom_range(1, 20);
      ul  = (len < MT0) ? 1'b1 : 1'($urandom_range(0, 1));
      qa.delete();
      qb.delete();
      for (int i = 0; i < len; i++) begin
        qa.push_back(int'($urandom_range(0, 255)) - 128);
        qb.push_back(int'($urandom_range(0, 255)) - 128);
      end
      model(MT0, e, es);
      ef = !(ul && len <= MT0);
      drive_sum(MT0, ul, 1'b1);
      total++;
      if (o_valid !== 1'b1 || o_int !== e || o_forced !== ef || o_sat !== es) begin
        bad++;
        $display("FAIL random_sum[%0d]: valid=%0b int=%0d forced=%0b sat=%0b, expected 1/%0d/%0b/%0b",
                 it, o_valid, o_int, o_forced, o_sat, $signed(e), ef, es);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      pulse_done();
      total++;
      if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
        bad++;
        $display("FAIL random_release[%0d]: valid=%0b ready=%0b, expected 0/1",
                 it, o_valid, o_ready);
      end
    end
  endtask

  task automatic test_sat();
    logic [AW-1:0] e;
    bit es;
    sel = 1'b1;
    qa.delete();
    qb.delete();
    for (int i = 0; i < 33; i++) begin qa.push_back(-128); qb.push_back(-128); end
    model(MT1, e, es);
    drive_sum(MT1, 1'b1, 1'b0);
    total++;
    if (o_valid !== 1'b1 || o_int !== e || o_sat !== es || o_forced !== 1'b0) begin
      bad++;
      $display("FAIL overflow_sum: valid=%0b int=%0d sat=%0b forced=%0b, expected 1/%0d/%0b/0",
               o_valid, o_int, o_sat, o_forced, $signed(e), es);
    end
    pulse_done();
    total++;
    if (o_valid !== 1'b0 || o_sat !== 1'b0) begin
      bad++;
      $display("FAIL overflow_release: valid=%0b sat=%0b, expected 0/0", o_valid, o_sat);
    end
    sel = 1'b0;
    #1;
  endtask

  task automatic test_reset_mid();
    sel = 1'b0;
    qa = '{1, 2};
    qb = '{4, 5};
    drive_sum(MT0, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_int !== '0 || o_forced !== 1'b0 ||
        o_sat !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_sum: ready=%0b valid=%0b int=%0d forced=%0b sat=%0b, expected 1/0/0/0/0",
               o_ready, o_valid, o_int, o_forced, o_sat);
    end
    rst_n = 1'b1;
    qa = '{2};
    qb = '{3};
    drive_sum(MT0, 1'b1, 1'b0);
    total++;
    if (o_valid !== 1'b1 || o_int !== 20'sd6) begin
      bad++;
      $display("FAIL reset_fresh_sum: valid=%0b int=%0d, expected 1/6", o_valid, o_int);
    end
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_int !== '0) begin
      bad++;
      $display("FAIL reset_mid_hold: valid=%0b ready=%0b int=%0d, expected 0/1/0",
               o_valid, o_ready, o_int);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_forced();
    test_hold_block();
    test_random();
    test_sat();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
